// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths. Both ends import
// the same state encoding, idle line level and default bit timing, so a
// transmitter and a receiver built with default parameters always agree.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Level of the serial line when no frame is in flight
    localparam logic LINE_IDLE = 1'b1;

    // Default frame timing and width shared by both ends
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0 .. CLKS_PER_BIT-1 while enabled and wraps to 0
// on the terminal count, pulsing tick for that one cycle.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset (count -> 0)
//   enable - count advances only while high
//   clear  - synchronous clear, overrides enable
//   tick   - high during the cycle the count sits at its terminal value
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    assign tick = enable && (count_q == TERMINAL);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial transmitter. Accepts a byte over a valid/ready handshake and sends it
// as one start bit (0), DATA_BITS data bits LSB first, and STOP_BITS stop bits
// (1), each held for CLKS_PER_BIT clocks.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset; aborts any frame in progress
//   data_in - byte to send, sampled only on an accepted handshake
//   valid   - data_in is valid
//   ready   - block can accept a byte (registered)
//   out     - serial line, idles high (registered)
//   busy    - frame in progress (registered)
//
// All three outputs come straight from flops. The line register follows the
// state one cycle later, so after an accept at edge t the start bit begins at
// edge t+1, while ready/busy track the state directly. That offset is what
// produces the single idle-high cycle between back-to-back frames.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 busy
);

    localparam int unsigned IDX_WIDTH = $clog2(DATA_BITS + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_DATA = IDX_WIDTH'(DATA_BITS - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_STOP = IDX_WIDTH'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_WIDTH-1:0] bit_idx_q, bit_idx_d;
    logic                 out_q, out_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic accept;
    logic tick;

    // ready_q is high exactly when the state register holds IDLE
    assign accept = valid && ready_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q != IDLE),
        .clear  (accept),
        .tick   (tick)
    );

    // Next-state logic; the bit index is reused to count stop bits
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = data_in;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs: line level from the current state, handshake
    // flags from the next state
    always_comb begin
        out_d = LINE_IDLE;
        case (state_q)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_q[0];
            default: out_d = LINE_IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            out_q     <= LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Stimulus pushes each accepted byte and its
// accept cycle into a queue; an independent line monitor detects start bits,
// captures whole frames sample by sample and compares them to the ideal
// waveform computed from the byte. A second instance covers the
// CLKS_PER_BIT=2 / STOP_BITS=2 corner.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int C      = 16;
    localparam int D      = 8;
    localparam int S      = 1;
    localparam int FRAME  = (1 + D + S) * C;
    localparam int C2     = 2;
    localparam int S2     = 2;
    localparam int FRAME2 = (1 + D + S2) * C2;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid   = 1'b0;
    logic       ready, out, busy;
    logic [7:0] data2   = 8'h00;
    logic       valid2  = 1'b0;
    logic       ready2, out2, busy2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_active = 0;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (D),
        .STOP_BITS    (S),
        .COUNT_WIDTH  (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .out     (out),
        .busy    (busy)
    );

    uart_tx #(
        .CLKS_PER_BIT (C2),
        .DATA_BITS    (D),
        .STOP_BITS    (S2),
        .COUNT_WIDTH  (4)
    ) dut2 (
        .clock   (clock),
        .reset   (reset),
        .data_in (data2),
        .valid   (valid2),
        .ready   (ready2),
        .out     (out2),
        .busy    (busy2)
    );

    // Ideal line level for sample i of a frame carrying byte b
    function automatic logic line_level(input logic [7:0] b, input int i, input int cpb);
        int pos;
        pos = i / cpb;
        if (pos == 0) return 1'b0;
        if (pos <= D) return b[pos-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Cycle counter: during the low phase after edge n, cyc == n
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Line monitor / scoreboard consumer
    initial begin : monitor
        logic       samples [FRAME];
        int         n;
        bit         have_exp;
        exp_t       cur;
        int         mism;
        int         first_bad;
        logic [7:0] rx;
        n = 0;
        have_exp = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_active = 0;
            end else if (mon_active) begin
                samples[n] = out;
                n++;
                if (n == FRAME) begin
                    mon_active = 0;
                    rx = 8'h00;
                    for (int k = 0; k < D; k++) rx[k] = samples[(k + 1) * C + C / 2];
                    if (have_exp) begin
                        mism = 0;
                        first_bad = -1;
                        for (int i = 0; i < FRAME; i++) begin
                            if (samples[i] !== line_level(cur.data, i, C)) begin
                                mism++;
                                if (first_bad < 0) first_bad = i;
                            end
                        end
                        $display("[TB] frame rx=0x%02h exp=0x%02h accepted@%0d bad_samples=%0d first_bad=%0d",
                                 rx, cur.data, cur.acc, mism, first_bad);
                        chk("frame_bad_samples", mism, 0);
                        chk("rx_byte", {24'h0, rx}, {24'h0, cur.data});
                    end
                end
            end else if (out === 1'b0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    have_exp = 0;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    have_exp = 1;
                    chk("start_latency", cyc - cur.acc, 1);
                end
                samples[0] = out;
                n = 1;
                mon_active = 1;
            end
        end
    end

    // Drive one byte; returns at the low phase of the accept cycle t, acc = t
    task automatic send(input logic [7:0] b, input bit hold, output int acc);
        int n;
        n = 0;
        data_in = b;
        valid = 1'b1;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", {31'h0, ready}, 1);
        if (ready !== 1'b1) begin
            valid = 1'b0;
            acc = -1;
            return;
        end
        exp_q.push_back('{data: b, acc: cyc + 1});
        $display("[TB] send 0x%02h accept@%0d", b, cyc + 1);
        @(negedge clock);
        if (!hold) valid = 1'b0;
        acc = cyc;
    endtask

    initial begin : stimulus
        int   a0, a1, n, mism;
        logic busy_seen, rl, rh, b2;
        logic [7:0] rb;

        // Asynchronous reset values
        #2 reset = 1'b0;
        #1;
        chk("reset_out",   {31'h0, out},   1);
        chk("reset_ready", {31'h0, ready}, 1);
        chk("reset_busy",  {31'h0, busy},  0);
        repeat (3) @(negedge clock);
        chk("reset_out2",  {31'h0, out2},  1);
        reset = 1'b1;
        @(negedge clock);

        // Single frame 0xA5: ready low for exactly 160 cycles
        send(8'hA5, 1'b0, a0);
        busy_seen = busy;
        n = 0;
        while (ready === 1'b0 && n < 400) begin
            n++;
            @(negedge clock);
        end
        chk("ready_low_cycles", n, 160);
        chk("busy_in_frame",    {31'h0, busy_seen}, 1);
        chk("busy_after_frame", {31'h0, busy}, 0);
        repeat (3) @(negedge clock);

        // Back-to-back with valid held
        send(8'h00, 1'b1, a0);
        send(8'hFF, 1'b0, a1);
        chk("b2b_spacing", a1 - a0, 161);
        repeat (170) @(negedge clock);

        // Handshake ignored mid-frame
        send(8'h3C, 1'b0, a0);
        data_in = 8'hC3;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            valid   = ~valid;
            data_in = ~data_in;
        end
        valid = 1'b0;
        repeat (200) @(negedge clock);

        // Reset in the middle of bit 3 of 0x81
        send(8'h81, 1'b0, a0);
        repeat (66) @(negedge clock);
        chk("pre_abort_out",  {31'h0, out},  0);
        chk("pre_abort_busy", {31'h0, busy}, 1);
        reset = 1'b0;
        #1;
        chk("abort_out",   {31'h0, out},   1);
        chk("abort_ready", {31'h0, ready}, 1);
        chk("abort_busy",  {31'h0, busy},  0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(8'h7E, 1'b0, a0);
        repeat (165) @(negedge clock);

        // Randomised traffic with random gaps and held valid
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send(rb, 1'($urandom_range(0, 1)), a0);
            repeat ($urandom_range(0, 4)) @(negedge clock);
        end
        valid = 1'b0;

        // Corner instance: CLKS_PER_BIT=2, STOP_BITS=2, byte 0x01
        data2  = 8'h01;
        valid2 = 1'b1;
        n = 0;
        while (ready2 !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        valid2 = 1'b0;
        mism = 0;
        rl = 1'bx;
        rh = 1'bx;
        b2 = 1'bx;
        for (int i = 0; i < FRAME2; i++) begin
            @(negedge clock);
            if (out2 !== line_level(8'h01, i, C2)) mism++;
            if (i == 0) b2 = busy2;
            if (i == FRAME2 - 2) rl = ready2;
            if (i == FRAME2 - 1) rh = ready2;
        end
        @(negedge clock);
        $display("[TB] corner frame 0x01 len=%0d bad_samples=%0d", FRAME2, mism);
        chk("corner_frame_bad_samples", mism, 0);
        chk("corner_busy",       {31'h0, b2},   1);
        chk("corner_ready_low",  {31'h0, rl},   0);
        chk("corner_ready_back", {31'h0, rh},   1);
        chk("corner_idle_after", {31'h0, out2}, 1);

        // Let the monitor drain every outstanding frame
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter paired with the receiver: accepts parallel bytes over a valid/ready handshake and drives them onto the serial line as 8N1-style frames (start bit, LSB-first data, stop bits). It sits directly upstream of the receive path, so its `out` line feeds the receiver's `in` input. Bit timing uses the same clocks-per-bit convention as the receiver, so a transmitter and receiver with equal parameters interoperate.

## Interface

- `CLKS_PER_BIT`, 16: clock cycles each bit is held on the line; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `COUNT_WIDTH`, 16: width of the bit-period counter; must satisfy `2^COUNT_WIDTH > CLKS_PER_BIT`.

- `clock`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `data_in`, input, `DATA_BITS`: byte to send; sampled only on an accepted handshake.
- `valid`, input, 1: `data_in` is valid.
- `ready`, output, 1: block can accept a byte.
- `out`, output, 1: serial line; idles high.
- `busy`, output, 1: a frame is in progress (any state other than IDLE).

## Operation

- **Reset values** (applied asynchronously while `reset` = 0): `out` = 1, `ready` = 1, `busy` = 0, state IDLE, counters 0, shift register 0.
- **States:** IDLE → START → DATA → STOP → IDLE.
- **IDLE:** `out` = 1 and `ready` = 1. When `valid` && `ready` at a rising edge, the block latches `data_in` into the shift register, clears the bit counters and enters START.
- **START:** `out` = 0 for `CLKS_PER_BIT` cycles, then enters DATA.
- **DATA:** `out` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles the register shifts right by one and the bit index increments.
  - After `DATA_BITS` bits the block enters STOP.
- **STOP:** `out` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles, then returns to IDLE.
- **Outside IDLE:** `ready` = 0 and `busy` = 1. `valid` and `data_in` are ignored, so dropping or changing them mid-frame has no effect.
- **Bit-period counter:** counts 0 .. `CLKS_PER_BIT` − 1 and wraps to 0 on the terminal count. The terminal count is the only event that advances bits or states.
- **Bit index:** width `clog2(DATA_BITS + 1)`; it never wraps within a frame.
- **Outputs are registered:** `out`, `ready` and `busy` all come straight from flops, with no combinational path from `valid` or `data_in`.
- **Reset mid-frame:** the frame is aborted immediately. `out` goes to 1 asynchronously and the block is in IDLE on the first edge after `reset` is released.

## Timing

- Handshake accepted at edge t. `out` falls at edge t+1 (start of the start bit).
- The start bit occupies cycles t+1 .. t+C, where C = `CLKS_PER_BIT`.
- Data bit k occupies cycles t+1+(k+1)·C .. t+(k+2)·C.
- The stop period ends at t+(1+`DATA_BITS`+`STOP_BITS`)·C. `ready` rises in the next cycle.
- Minimum accept-to-accept spacing is (1+`DATA_BITS`+`STOP_BITS`)·C + 1 cycles (161 with defaults). The single IDLE cycle keeps the line high between frames.
- Latency from accept to the first line transition is 1 cycle.

## Structure

- **Shared package `uart_pkg`:**
  - State enum: IDLE=0, START=1, DATA=2, STOP=3.
  - Idle line level constant: 1.
  - Default `CLKS_PER_BIT` and `DATA_BITS`, shared with the receive side so both ends agree.
- **Sub-module `uart_baud_tick`:** parameterised bit-period counter with enable, synchronous clear, active-low asynchronous reset and a one-cycle `tick` output on the terminal count. The top-level FSM, shift register and bit index stay in `uart_tx`.

## Test plan

- **Single frame, defaults:** send `0xA5`. Line shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each exactly 16 cycles. `ready` is 0 for 160 cycles and returns to 1 at cycle 161.
- **Back-to-back:** hold `valid` = 1 with `0x00` then `0xFF`. The second accept happens exactly 161 cycles after the first, and the line is high for exactly one cycle between frames.
- **Handshake ignore:** during a frame of `0x3C`, toggle `valid` and change `data_in` to `0xC3` every cycle. The transmitted bits match `0x3C` and no extra frame is sent.
- **Reset mid-frame:** assert `reset` = 0 at bit 3 of `0x81`. `out` = 1, `ready` = 1 and `busy` = 0 without waiting for a clock edge. After release, a new byte `0x7E` transmits correctly.
- **Parameter corner:** with `CLKS_PER_BIT` = 2 and `STOP_BITS` = 2, sending `0x01` gives a frame of 22 cycles, with the stop high for 4 cycles.
- **Loopback:** connect `out` to the receiver built with the same parameters and send `0x00`, `0x55`, `0xAA`, `0xFF`. The receiver outputs the identical bytes in order.
